// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch sequencer for a word-addressed instruction memory with a
//   combinational read. It owns the fetch PC, captures returned words into a
//   small prefetch queue and presents {pc, instr} to decode over valid/ready.
//   A redirect flushes the queue and restarts fetch. A halt request stops
//   fetching while the queue keeps draining.
//
// Parameters
//   AW        fetch PC width in words (memory depth 2**AW)
//   RESET_PC  word address fetched first after reset
//   QDEPTH    prefetch queue entries, power of two, >= 2
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   im_addr        word address to memory, zero-extended fetch PC
//   im_data        instruction word from memory, valid in the same cycle
//   out_valid      queue head valid
//   out_instr      queue head instruction (0 when empty)
//   out_pc         queue head word address (0 when empty)
//   out_ready      decode accepts the head this cycle
//   redirect       flush the queue and restart fetch at redirect_pc
//   redirect_pc    new word address
//   halt_req       stop fetching while high
//   fetching       FSM is in RUN
//
// Optional feature (macro IF_PERF_CNT_EN)
//   perf_fetch_cnt +1 per queue push, wraps at 2**32
//   perf_flush_cnt +1 per accepted redirect, wraps at 2**32
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
   parameter int unsigned AW       = 6,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic          clk,
   input  logic          rst,
   output logic [31:0]   im_addr,
   input  logic [31:0]   im_data,
   output logic          out_valid,
   output logic [31:0]   out_instr,
   output logic [AW-1:0] out_pc,
   input  logic          out_ready,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt_req,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]   perf_fetch_cnt,
   output logic [31:0]   perf_flush_cnt,
`endif
   output logic          fetching
);

   localparam int unsigned   PW    = $clog2(QDEPTH);
   localparam int unsigned   CW    = PW + 1;
   localparam logic [AW-1:0] RstPc = AW'(RESET_PC);
   localparam logic [CW-1:0] QFull = CW'(QDEPTH);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2
   } state_e;

   state_e        state_q, state_d;

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] q_pc_q    [QDEPTH];
   logic [31:0]   q_instr_q [QDEPTH];

   logic          flush;
   logic          pop;
   logic          push;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state. IDLE lasts exactly one cycle so memory settles after reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   state_d = StRun;
         StRun:    if (halt_req)  state_d = StHalted;
         StHalted: if (!halt_req) state_d = StRun;
         default:  state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      fetching = (state_q == StRun);
      // A redirect is ignored in IDLE; everywhere else it flushes and loads the PC.
      flush    = redirect && (state_q != StIdle);
   end

   // ---------------------------------------------------------------------------
   // Queue control and fetch PC
   // ---------------------------------------------------------------------------
   always_comb begin
      // The head shown during a redirect cycle is discarded, not consumed.
      pop        = out_valid && out_ready && !flush;
      // A full queue may still accept a word when the head leaves this cycle.
      push       = fetching && !redirect && ((count_q < QFull) || pop);

      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (flush) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + AW'(1);
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (!push && pop) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RstPc;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Queue storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            q_pc_q[PW'(i)]    <= '0;
            q_instr_q[PW'(i)] <= '0;
         end
      end else if (push) begin
         q_pc_q[wr_ptr_q]    <= fetch_pc_q;
         q_instr_q[wr_ptr_q] <= im_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. No bypass: a pushed word appears one cycle after its push.
   // ---------------------------------------------------------------------------
   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? q_pc_q[rd_ptr_q]    : '0;
   assign out_instr = out_valid ? q_instr_q[rd_ptr_q] : '0;
   assign im_addr   = {{(32-AW){1'b0}}, fetch_pc_q};

`ifdef IF_PERF_CNT_EN
   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (push) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (flush) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge. A queue-based model tracks what decode
// should see. A second instance with RESET_PC=62 exercises PC wrap.
module tb_if_fetch_ctrl;

   localparam int AW = 6;
   localparam int QD = 2;
   localparam int MIdle = 0, MRun = 1, MHalted = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   im_addr, im_data, out_instr;
   logic [31:0]   im_addr2, im_data2, out_instr2;
   logic          out_valid, fetching, out_valid2, fetching2;
   logic [AW-1:0] out_pc, out_pc2;
   logic          out_ready = 1'b0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          halt_req = 1'b0;
`ifdef IF_PERF_CNT_EN
   logic [31:0]   pf1, pl1, pf2, pl2;
`endif

   logic [31:0]   mem [64];
   assign im_data  = mem[im_addr[AW-1:0]];
   assign im_data2 = mem[im_addr2[AW-1:0]];

   always #5 clk = ~clk;

   if_fetch_ctrl #(.AW(AW), .RESET_PC(0), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt(pf1), .perf_flush_cnt(pl1),
`endif
      .fetching(fetching)
   );

   if_fetch_ctrl #(.AW(AW), .RESET_PC(62), .QDEPTH(QD)) dut2 (
      .clk(clk), .rst(rst), .im_addr(im_addr2), .im_data(im_data2),
      .out_valid(out_valid2), .out_instr(out_instr2), .out_pc(out_pc2), .out_ready(out_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt(pf2), .perf_flush_cnt(pl2),
`endif
      .fetching(fetching2)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------------------------------------------------------------------
   // Reference model: a plain queue of fetched words plus the next PC to fetch.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   instr;
   } entry_t;

   entry_t        mq[$];
   logic [AW-1:0] m_pc;
   int            m_state;
   logic [31:0]   m_fetch, m_flush;

   task automatic model_reset();
      mq.delete();
      m_pc    = '0;
      m_state = MIdle;
      m_fetch = '0;
      m_flush = '0;
   endtask

   // Advance the model by one clock using the inputs of the current cycle.
   task automatic model_tick();
      bit     fl, pp, ps;
      entry_t e;
      fl = redirect && (m_state != MIdle);
      pp = (mq.size() != 0) && out_ready && !fl;
      ps = (m_state == MRun) && !redirect && ((mq.size() < QD) || pp);
      if (fl) begin
         mq.delete();
         m_pc = redirect_pc;
         m_flush = m_flush + 1;
      end else begin
         if (pp) void'(mq.pop_front());
         if (ps) begin
            e.pc = m_pc;
            e.instr = mem[m_pc];
            mq.push_back(e);
            m_pc = m_pc + 1'b1;
            m_fetch = m_fetch + 1;
         end
      end
      if (m_state == MIdle) m_state = MRun;
      else m_state = halt_req ? MHalted : MRun;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks += 6;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset valid: got %b want 0", out_valid); end
      if (out_pc !== '0) begin n_errors++; $display("FAIL reset pc: got %0d want 0", out_pc); end
      if (out_instr !== '0) begin n_errors++; $display("FAIL reset instr: got %h want 0", out_instr); end
      if (fetching !== 1'b0) begin n_errors++; $display("FAIL reset fetching: got %b want 0", fetching); end
      if (im_addr !== 32'd0) begin n_errors++; $display("FAIL reset im_addr: got %0d want 0", im_addr); end
      if (im_addr2 !== 32'd62) begin n_errors++; $display("FAIL reset im_addr2: got %0d want 62", im_addr2); end
      rst = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_stream();
      int            first = -1;
      logic [AW-1:0] seen[$];
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_checks += 3;
         if (out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL stream valid: got %b want %b", out_valid, mq.size() != 0); end
         if (im_addr !== {26'd0, m_pc}) begin n_errors++; $display("FAIL stream im_addr: got %0d want %0d", im_addr, m_pc); end
         if (fetching !== (m_state == MRun)) begin n_errors++; $display("FAIL stream fetching: got %b want %b", fetching, m_state == MRun); end
         if (mq.size() != 0) begin
            n_checks++;
            if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin n_errors++; $display("FAIL stream head: got %0d/%h want %0d/%h", out_pc, out_instr, mq[0].pc, mq[0].instr); end
         end
         if (out_valid === 1'b1) begin
            if (first < 0) first = c;
            seen.push_back(out_pc);
         end
         model_tick();
         @(posedge clk); #1;
      end
      n_checks += 2;
      if (first != 2) begin n_errors++; $display("FAIL stream first_valid: got cycle %0d want 2", first); end
      if (seen.size() < 5) begin n_errors++; $display("FAIL stream count: got %0d want >=5", seen.size()); end
      else for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (seen[i] !== AW'(i)) begin n_errors++; $display("FAIL stream order: got %0d want %0d", seen[i], i); end
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_checks += 2;
         if (out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL bp valid: got %b want %b", out_valid, mq.size() != 0); end
         if (im_addr !== {26'd0, m_pc}) begin n_errors++; $display("FAIL bp im_addr: got %0d want %0d", im_addr, m_pc); end
         model_tick();
         @(posedge clk); #1;
      end
      n_checks++;
      if (im_addr !== 32'd2) begin n_errors++; $display("FAIL bp hold_addr: got %0d want 2", im_addr); end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks += 2;
         if (out_valid !== 1'b1 || out_pc !== AW'(c)) begin n_errors++; $display("FAIL bp drain: got %b/%0d want 1/%0d", out_valid, out_pc, c); end
         if (mq.size() == 0 || out_instr !== mq[0].instr) begin n_errors++; $display("FAIL bp instr: got %h want %h", out_instr, 32'h1000 + c); end
         model_tick();
         @(posedge clk); #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_redirect();
      do_reset();
      for (int c = 0; c < 20 && !(mq.size() == 2 && mq[0].pc == 3); c++) begin
         out_ready = !(mq.size() == 1 && mq[0].pc >= 2);
         @(negedge clk);
         n_checks++;
         if (out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL redir setup valid: got %b want %b", out_valid, mq.size() != 0); end
         model_tick();
         @(posedge clk); #1;
      end
      n_checks++;
      if (!(mq.size() == 2 && mq[0].pc == 3)) begin n_errors++; $display("FAIL redir setup: queue size %0d, want pcs 3,4", mq.size()); end
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 6'd10;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 6'd3) begin n_errors++; $display("FAIL redir head: got %b/%0d want 1/3", out_valid, out_pc); end
      model_tick();
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL redir bubble: got %b want 0", out_valid); end
      if (im_addr !== 32'd10) begin n_errors++; $display("FAIL redir im_addr: got %0d want 10", im_addr); end
      model_tick();
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 6'd10 || out_instr !== 32'h100A) begin n_errors++; $display("FAIL redir target: got %b/%0d/%h want 1/10/100a", out_valid, out_pc, out_instr); end
      model_tick();
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 6'd11) begin n_errors++; $display("FAIL redir next: got %b/%0d want 1/11", out_valid, out_pc); end
      model_tick();
      @(posedge clk); #1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_wrap();
      logic [AW-1:0] seen[$];
      logic [AW-1:0] want[4];
      want[0] = 6'd62; want[1] = 6'd63; want[2] = 6'd0; want[3] = 6'd1;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_checks++;
         if (im_addr2[31:AW] !== '0) begin n_errors++; $display("FAIL wrap im_addr: got %0d want <=63", im_addr2); end
         if (out_valid2 === 1'b1) seen.push_back(out_pc2);
         model_tick();
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen.size() < 4) begin n_errors++; $display("FAIL wrap count: got %0d want >=4", seen.size()); end
      else for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (seen[i] !== want[i]) begin n_errors++; $display("FAIL wrap order: got %0d want %0d", seen[i], want[i]); end
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_halt();
      logic [31:0]   frozen = '0;
      logic [AW-1:0] lastpc = '0;
      bit            resumed = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         halt_req = (c >= 2 && c < 6);
         @(negedge clk);
         n_checks += 3;
         if (out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL halt valid: got %b want %b", out_valid, mq.size() != 0); end
         if (im_addr !== {26'd0, m_pc}) begin n_errors++; $display("FAIL halt im_addr: got %0d want %0d", im_addr, m_pc); end
         if (fetching !== (m_state == MRun)) begin n_errors++; $display("FAIL halt fetching: got %b want %b", fetching, m_state == MRun); end
         if (c == 3) frozen = im_addr;
         if (c == 5) begin
            n_checks++;
            if (out_valid !== 1'b0 || fetching !== 1'b0 || im_addr !== frozen) begin n_errors++; $display("FAIL halt frozen: got %b/%b/%0d want 0/0/%0d", out_valid, fetching, im_addr, frozen); end
         end
         if (out_valid === 1'b1 && c < 6) lastpc = out_pc;
         if (out_valid === 1'b1 && c >= 6 && !resumed) begin
            resumed = 1'b1;
            n_checks++;
            if (out_pc !== lastpc + 1'b1) begin n_errors++; $display("FAIL halt resume: got %0d want %0d", out_pc, lastpc + 1'b1); end
         end
         model_tick();
         @(posedge clk); #1;
      end
      halt_req = 1'b0;
      n_checks++;
      if (!resumed) begin n_errors++; $display("FAIL halt resume: got no valid want pc %0d", lastpc + 1'b1); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid();
      out_ready = 1'b1;
      rst = 1'b0;
      #1;
      n_checks += 3;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid valid: got %b want 0", out_valid); end
      if (fetching !== 1'b0) begin n_errors++; $display("FAIL rstmid fetching: got %b want 0", fetching); end
      if (im_addr !== 32'd0) begin n_errors++; $display("FAIL rstmid im_addr: got %0d want 0", im_addr); end
`ifdef IF_PERF_CNT_EN
      n_checks++;
      if (pf1 !== 32'd0 || pl1 !== 32'd0) begin n_errors++; $display("FAIL rstmid perf: got %0d/%0d want 0/0", pf1, pl1); end
`endif
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 2) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 6'd0) begin n_errors++; $display("FAIL rstmid restart: got %b/%0d want 1/0", out_valid, out_pc); end
         end
         model_tick();
         @(posedge clk); #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_random();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         out_ready   = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = AW'($urandom);
         if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
         @(negedge clk);
         n_checks += 3;
         if (out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL rand valid: got %b want %b", out_valid, mq.size() != 0); end
         if (im_addr !== {26'd0, m_pc}) begin n_errors++; $display("FAIL rand im_addr: got %0d want %0d", im_addr, m_pc); end
         if (fetching !== (m_state == MRun)) begin n_errors++; $display("FAIL rand fetching: got %b want %b", fetching, m_state == MRun); end
         if (mq.size() != 0) begin
            n_checks++;
            if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin n_errors++; $display("FAIL rand head: got %0d/%h want %0d/%h", out_pc, out_instr, mq[0].pc, mq[0].instr); end
         end
`ifdef IF_PERF_CNT_EN
         n_checks++;
         if (pf1 !== m_fetch || pl1 !== m_flush) begin n_errors++; $display("FAIL rand perf: got %0d/%0d want %0d/%0d", pf1, pl1, m_fetch, m_flush); end
`endif
         model_tick();
         @(posedge clk); #1;
      end
      redirect = 1'b0;
      halt_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
